// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmit path: FSM encodings,
// frame bit indices, common command bytes and the frame parity helper.
package ps2_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_INHIBIT   = 3'd1;
    localparam logic [2:0] ST_XFER      = 3'd2;
    localparam logic [2:0] ST_ACK       = 3'd3;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        INHIBIT   = ST_INHIBIT,
        XFER      = ST_XFER,
        ACK       = ST_ACK,
        WAIT_IDLE = ST_WAIT_IDLE
    } ps2_state_e;

    localparam logic [3:0] PAR_IDX  = 4'd8;
    localparam logic [3:0] STOP_IDX = 4'd9;

    localparam logic [7:0] CMD_SET_LEDS      = 8'hED;
    localparam logic [7:0] CMD_ENABLE_REPORT = 8'hF4;
    localparam logic [7:0] CMD_RESET         = 8'hFF;

    // PS/2 frames carry odd parity over the eight data bits.
    function automatic logic odd_parity(input logic [7:0] i_byte);
        return ~^i_byte;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus FILTER_LEN-sample debounce for one PS/2 line,
// producing a clean level and a one-cycle pulse on each filtered 1->0 edge.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_line,
    output logic o_level,
    output logic o_fall
);

    localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] SETTLE = CW'(FILTER_LEN - 1);

    logic [1:0]    r_sync;
    logic          r_level;
    logic          r_fall;
    logic [CW-1:0] r_cnt;
    logic          w_diff;
    logic          w_settled;

    assign w_diff    = (r_sync[1] != r_level);
    assign w_settled = (r_cnt == SETTLE);

    // Level only changes after FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync  <= '1;
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_line};
            r_fall <= 1'b0;
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_settled) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
                r_fall  <= r_level;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues the start bit,
// shifts a command byte out on device clock falls and checks the device ACK.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2clk_in,
    input  logic       ps2data_in,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       ps2clk_oe,
    output logic       ps2data_oe,
    output logic       enable_rcv,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_PRE  = CNT_W'(INHIBIT_CYCLES - 2);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    ps2_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_bitcnt;
    logic [7:0]       r_shift;
    logic             r_par;
    logic [1:0]       r_dsync;
    logic             r_clk_oe;
    logic             r_data_oe;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic             w_clk_level;
    logic             w_clk_fall;
    logic             w_line_phase;
    logic             w_timeout;

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk    (clk),
        .reset  (reset),
        .i_line (ps2clk_in),
        .o_level(w_clk_level),
        .o_fall (w_clk_fall)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dsync <= '1;
        end else begin
            r_dsync <= {r_dsync[0], ps2data_in};
        end
    end

    // Device-paced phases share one inactivity counter, cleared on every fall.
    assign w_line_phase = (r_state == XFER) || (r_state == ACK) || (r_state == WAIT_IDLE);
    assign w_timeout    = w_line_phase && !w_clk_fall && (r_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (w_timeout) begin
                r_clk_oe  <= 1'b0;
                r_data_oe <= 1'b0;
                r_done    <= 1'b1;
                r_err     <= 1'b1;
                r_busy    <= 1'b0;
                r_state   <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (tx_start) begin
                            r_shift   <= tx_data;
                            r_par     <= odd_parity(tx_data);
                            r_busy    <= 1'b1;
                            r_clk_oe  <= 1'b1;
                            r_data_oe <= 1'b0;
                            r_cnt     <= '0;
                            r_state   <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        r_cnt <= r_cnt + 1'b1;
                        // Start bit goes out one cycle before the clock is released.
                        if (r_cnt == INH_PRE) begin
                            r_data_oe <= 1'b1;
                        end
                        if (r_cnt == INH_LAST) begin
                            r_clk_oe <= 1'b0;
                            r_cnt    <= '0;
                            r_bitcnt <= '0;
                            r_state  <= XFER;
                        end
                    end
                    XFER: begin
                        r_cnt <= w_clk_fall ? '0 : r_cnt + 1'b1;
                        if (w_clk_fall) begin
                            r_bitcnt <= r_bitcnt + 1'b1;
                            if (r_bitcnt < PAR_IDX) begin
                                r_data_oe <= ~r_shift[r_bitcnt[2:0]];
                            end else if (r_bitcnt == PAR_IDX) begin
                                r_data_oe <= ~r_par;
                            end else if (r_bitcnt == STOP_IDX) begin
                                r_data_oe <= 1'b0;
                                r_state   <= ACK;
                            end
                        end
                    end
                    ACK: begin
                        r_cnt <= w_clk_fall ? '0 : r_cnt + 1'b1;
                        if (w_clk_fall) begin
                            r_par   <= r_dsync[1];
                            r_state <= WAIT_IDLE;
                        end
                    end
                    WAIT_IDLE: begin
                        r_cnt <= w_clk_fall ? '0 : r_cnt + 1'b1;
                        // r_par is reused to hold the missing-ACK flag.
                        if (w_clk_level && r_dsync[1]) begin
                            r_done  <= 1'b1;
                            r_err   <= r_par;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                    default: begin
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end
                endcase
            end
        end
    end

    assign ps2clk_oe  = r_clk_oe;
    assign ps2data_oe = r_data_oe;
    assign enable_rcv = ~r_busy;
    assign tx_busy    = r_busy;
    assign tx_done    = r_done;
    assign tx_err     = r_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: open-drain pin model plus a PS/2 device
// model that clocks frames, samples the bits and optionally ACKs.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 40;
    localparam int TO  = 300;
    localparam int FL  = 4;
    localparam int H   = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       ps2clk_oe, ps2data_oe, enable_rcv, tx_busy, tx_done, tx_err;
    logic       dev_clk_low, dev_data_low;
    logic       ps2clk_pin, ps2data_pin;

    int n_vec  = 0;
    int n_miss = 0;

    int cyc = 0, last_fall_cyc = 0, done_cyc = 0;
    int done_cnt = 0, long_pulse = 0;
    logic last_err = 1'b0;
    logic prev_pin = 1'b1, prev_done = 1'b0;

    assign ps2clk_pin  = ~(ps2clk_oe | dev_clk_low);
    assign ps2data_pin = ~(ps2data_oe | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO),
        .FILTER_LEN    (FL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2clk_in (ps2clk_pin),
        .ps2data_in(ps2data_pin),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .ps2clk_oe (ps2clk_oe),
        .ps2data_oe(ps2data_oe),
        .enable_rcv(enable_rcv),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .tx_err    (tx_err)
    );

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (prev_pin && !ps2clk_pin) last_fall_cyc = cyc;
        prev_pin = ps2clk_pin;
        if (tx_done) begin
            done_cnt = done_cnt + 1;
            last_err = tx_err;
            done_cyc = cyc;
            if (prev_done) long_pulse = long_pulse + 1;
        end
        prev_done = tx_done;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_tx(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    // bits[0]=start, [8:1]=data LSB first, [9]=parity, [10]=stop
    task automatic dev_frame(input int n_falls, input bit ack, output logic [10:0] bits, output bit ok);
        int w = 0;
        bits = '0;
        ok   = 1'b1;
        while (!(ps2clk_pin && !ps2data_pin) && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 2000) begin
            ok = 1'b0;
            return;
        end
        bits[0] = ps2data_pin;
        for (int i = 1; i <= n_falls; i++) begin
            if (i == 11 && ack) begin
                repeat (H / 2) @(negedge clk);
                dev_data_low = 1'b1;
            end
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b0;
            if (i <= 10) bits[i] = ps2data_pin;
        end
        if (n_falls >= 11) begin
            repeat (H) @(negedge clk);
            dev_data_low = 1'b0;
        end
    endtask

    task automatic wait_done(input string tag, input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] b, input bit ack,
                             input logic [10:0] exp_bits, input bit exp_err, input bit chk_inh);
        int d0  = done_cnt;
        int lp0 = long_pulse;
        int n   = 0;
        int ov  = 0;
        logic [10:0] bits;
        bit ok;
        start_tx(b);
        if (chk_inh) begin
            chk({tag, "_busy"}, 32'(tx_busy), 32'd1);
            chk({tag, "_enable_rcv"}, 32'(enable_rcv), 32'd0);
            chk({tag, "_clk_oe"}, 32'(ps2clk_oe), 32'd1);
            while (ps2clk_oe && n < 1000) begin
                if (ps2data_oe) ov++;
                n++;
                @(negedge clk);
            end
            chk({tag, "_inhibit_len"}, 32'(n), 32'(INH));
            chk({tag, "_start_overlap"}, 32'(ov), 32'd1);
            chk({tag, "_start_bit_held"}, 32'(ps2data_oe), 32'd1);
        end
        dev_frame(11, ack, bits, ok);
        chk({tag, "_dev_sync"}, 32'(ok), 32'd1);
        chk({tag, "_frame_bits"}, 32'(bits), 32'(exp_bits));
        wait_done(tag, d0);
        chk({tag, "_err"}, 32'(last_err), 32'(exp_err));
        chk({tag, "_oe_released"}, {30'd0, ps2clk_oe, ps2data_oe}, 32'd0);
        chk({tag, "_enable_rcv_after"}, 32'(enable_rcv), 32'd1);
        chk({tag, "_done_width"}, 32'(long_pulse - lp0), 32'd0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] bits;
        bit ok;
        int d0;
        int el;

        reset        = 1'b1;
        tx_start     = 1'b1;
        tx_data      = CMD_SET_LEDS;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_clk_oe", 32'(ps2clk_oe), 32'd0);
        chk("rst_data_oe", 32'(ps2data_oe), 32'd0);
        chk("rst_enable_rcv", 32'(enable_rcv), 32'd1);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_done", 32'(tx_done), 32'd0);
        chk("rst_err", 32'(tx_err), 32'd0);
        tx_start = 1'b0;
        reset    = 1'b0;
        repeat (10) @(negedge clk);

        run_frame("ed", CMD_SET_LEDS, 1'b1, 11'h7DA, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        run_frame("f4", CMD_ENABLE_REPORT, 1'b1, 11'h5E8, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        run_frame("noack", CMD_RESET, 1'b0, 11'h7FE, 1'b1, 1'b0);
        repeat (20) @(negedge clk);

        // device stops clocking after bit 3
        d0 = done_cnt;
        start_tx(CMD_ENABLE_REPORT);
        dev_frame(4, 1'b0, bits, ok);
        chk("to_dev_sync", 32'(ok), 32'd1);
        wait_done("to", d0);
        el = done_cyc - last_fall_cyc;
        chk("to_window", 32'(el >= TO && el <= TO + FL + 8), 32'd1);
        chk("to_err", 32'(last_err), 32'd1);
        chk("to_oe", {30'd0, ps2clk_oe, ps2data_oe}, 32'd0);
        chk("to_busy", 32'(tx_busy), 32'd0);
        chk("to_state", {29'd0, dut.r_state}, {29'd0, ST_IDLE});
        repeat (20) @(negedge clk);

        // second request mid-transfer must be dropped
        d0 = done_cnt;
        start_tx(CMD_SET_LEDS);
        fork
            dev_frame(11, 1'b1, bits, ok);
            begin
                repeat (150) @(negedge clk);
                chk("busy_mid", 32'(tx_busy), 32'd1);
                tx_data  = 8'h00;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
            end
        join
        chk("busy_frame_bits", 32'(bits), 32'h7DA);
        wait_done("busy", d0);
        chk("busy_err", 32'(last_err), 32'd0);
        repeat (600) @(negedge clk);
        chk("busy_no_queue", 32'(done_cnt - d0), 32'd1);
        chk("busy_idle", 32'(tx_busy), 32'd0);

        // reset while bit 5 is on the line
        d0 = done_cnt;
        start_tx(8'h00);
        dev_frame(6, 1'b0, bits, ok);
        chk("rstmid_data_oe", 32'(ps2data_oe), 32'd1);
        chk("rstmid_busy", 32'(tx_busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid_oe", {30'd0, ps2clk_oe, ps2data_oe}, 32'd0);
        chk("rstmid_busy_clr", 32'(tx_busy), 32'd0);
        reset = 1'b0;
        repeat (600) @(negedge clk);
        chk("rstmid_no_done", 32'(done_cnt - d0), 32'd0);
        run_frame("post_rst", CMD_ENABLE_REPORT, 1'b1, 11'h5E8, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
